// File: rtl/csa_pkg.sv
// Shared definitions for the carry-save accumulator sequencer:
// FSM state encoding and a constant-width helper.
package csa_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCUM   = 2'd1,
        RESOLVE = 2'd2,
        DONE    = 2'd3
    } state_t;

    // Ceiling log2, usable in parameter expressions.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/csa.sv
// 3:2 carry-save adder: bitwise sum and majority (unshifted carry).
// Ports: a, b, c (W) in; sum, maj (W) out.
module csa #(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] c,
    output logic [W-1:0] sum,
    output logic [W-1:0] maj
);

    assign sum = a ^ b ^ c;
    assign maj = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/csa_accum_seq.sv
// Streams N-bit operands into a carry-save running sum, then resolves it.
// Ports: clk, rst_n; in_valid/in_ready/in_data/in_last operand stream;
// out_valid/out_ready/out_sum/out_count/out_trunc result; busy.
module csa_accum_seq
    import csa_pkg::*;
#(
    parameter int  N       = 4,
    parameter int  MAX_OPS = 8,
    localparam int W       = N + clog2(MAX_OPS),
    localparam int CW      = clog2(MAX_OPS + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  in_data,
    input  logic          in_last,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_sum,
    output logic [CW-1:0] out_count,
    output logic          out_trunc,
    output logic          busy
);

    state_t        state;
    logic [W-1:0]  s_q;
    logic [W-1:0]  c_q;
    logic [CW-1:0] cnt;
    logic [W-1:0]  x;
    logic [W-1:0]  s_nx;
    logic [W-1:0]  maj;
    logic          accept;
    logic          forced;
    logic          term;

    assign x      = {{(W-N){1'b0}}, in_data};
    assign accept = in_valid & in_ready;
    // This beat fills the last available slot.
    assign forced = (cnt == CW'(MAX_OPS - 1));
    assign term   = in_last | forced;

    assign in_ready  = (state == IDLE) || (state == ACCUM);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);

    csa #(.W(W)) u_csa (
        .a   (s_q),
        .b   (c_q),
        .c   (x),
        .sum (s_nx),
        .maj (maj)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            s_q       <= '0;
            c_q       <= '0;
            cnt       <= '0;
            out_sum   <= '0;
            out_count <= '0;
            out_trunc <= 1'b0;
        end else begin
            unique case (state)
                IDLE, ACCUM: begin
                    if (accept) begin
                        s_q <= s_nx;
                        // Carry MSB is provably zero for W; drop it.
                        c_q <= W'(maj << 1);
                        cnt <= cnt + CW'(1);
                        if (term) begin
                            state     <= RESOLVE;
                            out_trunc <= forced & ~in_last;
                        end else begin
                            state <= ACCUM;
                        end
                    end
                end
                RESOLVE: begin
                    out_sum   <= s_q + c_q;
                    out_count <= cnt;
                    state     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                        s_q   <= '0;
                        c_q   <= '0;
                        cnt   <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
